// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages (conv, maxpool).
//   state_t   : control FSM states used by the pipeline stages
//   out_dim   : output feature-map dimension from input size, window, stride and padding
//   idx_width : counter width for a given index range, never below one bit
package cnn_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_PROCESS = 2'd1,
    STATE_DONE    = 2'd2
  } state_t;

  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned win,
                                          input int unsigned stride, input int unsigned pad);
    return (in_dim + 2 * pad - win) / stride + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/maxpool_if.sv
// Data/handshake bundle between the conv stage, the maxpool stage and its consumer.
//   en        : start/hold request (driven by the conv stage's done_conv)
//   ifmap     : input feature map, held stable while the pool stage is busy
//   ofmap     : pooled output map, registered inside the pool stage
//   done_pool : high while the pool stage sits in its done state
// master = upstream/consumer side, slave = maxpool side.
interface maxpool_if #(
  parameter int unsigned IFMAP_HEIGHT = 4,
  parameter int unsigned IFMAP_WIDTH  = 4,
  parameter int unsigned OFMAP_HEIGHT = 2,
  parameter int unsigned OFMAP_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH   = 8
);

  logic                                                     en;
  logic [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1][DATA_WIDTH-1:0] ifmap;
  logic [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1][DATA_WIDTH-1:0] ofmap;
  logic                                                     done_pool;

  modport master (
    output en,
    output ifmap,
    input  ofmap,
    input  done_pool
  );

  modport slave (
    input  en,
    input  ifmap,
    output ofmap,
    output done_pool
  );

endinterface

// File: rtl/pool_window_ctr.sv
// Nested scan counters for a pooling pass: window column, window row, output column,
// output row (innermost first).
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : force all counters to zero (has priority over advance)
//   advance     : step to the next window element
//   win_row/col : position inside the current window
//   out_row/col : current output pixel (window origin / stride)
//   last_elem   : current element is the last one of its window
//   last_window : current element is the last one of the last window
module pool_window_ctr
  import cnn_pkg::*;
#(
  parameter int unsigned POOL_HEIGHT  = 2,
  parameter int unsigned POOL_WIDTH   = 2,
  parameter int unsigned OFMAP_HEIGHT = 2,
  parameter int unsigned OFMAP_WIDTH  = 2,
  localparam int unsigned WR_W = idx_width(POOL_HEIGHT),
  localparam int unsigned WC_W = idx_width(POOL_WIDTH),
  localparam int unsigned OR_W = idx_width(OFMAP_HEIGHT),
  localparam int unsigned OC_W = idx_width(OFMAP_WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [WR_W-1:0] win_row,
  output logic [WC_W-1:0] win_col,
  output logic [OR_W-1:0] out_row,
  output logic [OC_W-1:0] out_col,
  output logic            last_elem,
  output logic            last_window
);

  localparam logic [WR_W-1:0] WR_MAX = WR_W'(POOL_HEIGHT - 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(POOL_WIDTH - 1);
  localparam logic [OR_W-1:0] OR_MAX = OR_W'(OFMAP_HEIGHT - 1);
  localparam logic [OC_W-1:0] OC_MAX = OC_W'(OFMAP_WIDTH - 1);

  assign last_elem   = (win_row == WR_MAX) && (win_col == WC_MAX);
  assign last_window = last_elem && (out_row == OR_MAX) && (out_col == OC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_row <= '0;
      win_col <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (clear) begin
      win_row <= '0;
      win_col <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (advance) begin
      if (win_col != WC_MAX) begin
        win_col <= win_col + 1'b1;
      end else begin
        win_col <= '0;
        if (win_row != WR_MAX) begin
          win_row <= win_row + 1'b1;
        end else begin
          win_row <= '0;
          if (out_col != OC_MAX) begin
            out_col <= out_col + 1'b1;
          end else begin
            out_col <= '0;
            out_row <= (out_row == OR_MAX) ? '0 : out_row + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/maxpool.sv
// Max-pooling stage behind the convolution stage. Scans each pooling window one element
// per cycle, keeps a running unsigned maximum and writes one pooled pixel per window
// into a registered output map, then raises done_pool until en is released.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : maxpool_if slave (en, ifmap in; ofmap, done_pool out)
module maxpool
  import cnn_pkg::*;
#(
  parameter int unsigned IFMAP_HEIGHT = 4,
  parameter int unsigned IFMAP_WIDTH  = 4,
  parameter int unsigned POOL_HEIGHT  = 2,
  parameter int unsigned POOL_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned H_STRIDE     = 2,
  parameter int unsigned V_STRIDE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  maxpool_if.slave   bus
);

  localparam int unsigned OFMAP_HEIGHT = out_dim(IFMAP_HEIGHT, POOL_HEIGHT, V_STRIDE, 0);
  localparam int unsigned OFMAP_WIDTH  = out_dim(IFMAP_WIDTH, POOL_WIDTH, H_STRIDE, 0);
  localparam int unsigned IR_W = idx_width(IFMAP_HEIGHT);
  localparam int unsigned IC_W = idx_width(IFMAP_WIDTH);
  localparam int unsigned WR_W = idx_width(POOL_HEIGHT);
  localparam int unsigned WC_W = idx_width(POOL_WIDTH);
  localparam int unsigned OR_W = idx_width(OFMAP_HEIGHT);
  localparam int unsigned OC_W = idx_width(OFMAP_WIDTH);

  if (POOL_HEIGHT > IFMAP_HEIGHT || POOL_WIDTH > IFMAP_WIDTH) begin : g_bad_window
    $fatal(1, "maxpool: pooling window larger than the input map");
  end
  if (H_STRIDE < 1 || V_STRIDE < 1) begin : g_bad_stride
    $fatal(1, "maxpool: strides must be at least 1");
  end

  state_t                current_state;
  logic [WR_W-1:0]       win_row;
  logic [WC_W-1:0]       win_col;
  logic [OR_W-1:0]       out_row;
  logic [OC_W-1:0]       out_col;
  logic                  last_elem;
  logic                  last_window;
  logic                  clear;
  logic                  advance;
  logic [IR_W-1:0]       in_row;
  logic [IC_W-1:0]       in_col;
  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH-1:0] new_max;
  logic [DATA_WIDTH-1:0] run_max;
  logic                  done_pool_q;
  logic [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1][DATA_WIDTH-1:0] ofmap_q;

  // Counters only move while a pass is actively running; any other situation (idle,
  // done, abort, final element) parks them at the first element of window (0,0).
  always_comb begin
    clear   = 1'b1;
    advance = 1'b0;
    if (current_state == STATE_PROCESS && bus.en && !last_window) begin
      clear   = 1'b0;
      advance = 1'b1;
    end
  end

  pool_window_ctr #(
    .POOL_HEIGHT  (POOL_HEIGHT),
    .POOL_WIDTH   (POOL_WIDTH),
    .OFMAP_HEIGHT (OFMAP_HEIGHT),
    .OFMAP_WIDTH  (OFMAP_WIDTH)
  ) u_ctr (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .advance     (advance),
    .win_row     (win_row),
    .win_col     (win_col),
    .out_row     (out_row),
    .out_col     (out_col),
    .last_elem   (last_elem),
    .last_window (last_window)
  );

  // Leftover rows/columns past the last full window are never addressed.
  assign in_row  = IR_W'(32'(out_row) * V_STRIDE + 32'(win_row));
  assign in_col  = IC_W'(32'(out_col) * H_STRIDE + 32'(win_col));
  assign elem    = bus.ifmap[in_row][in_col];
  assign new_max = (elem > run_max) ? elem : run_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_state <= STATE_IDLE;
      run_max       <= '0;
      ofmap_q       <= '0;
      done_pool_q   <= 1'b0;
    end else begin
      unique case (current_state)
        STATE_IDLE: begin
          run_max <= '0;
          if (bus.en) begin
            current_state <= STATE_PROCESS;
          end
        end
        STATE_PROCESS: begin
          if (!bus.en) begin
            // Abort: pixels already written stay in ofmap.
            current_state <= STATE_IDLE;
            run_max       <= '0;
          end else if (last_elem) begin
            ofmap_q[out_row][out_col] <= new_max;
            run_max                   <= '0;
            if (last_window) begin
              current_state <= STATE_DONE;
              done_pool_q   <= 1'b1;
            end
          end else begin
            run_max <= new_max;
          end
        end
        STATE_DONE: begin
          if (!bus.en) begin
            current_state <= STATE_IDLE;
            done_pool_q   <= 1'b0;
          end
        end
        default: begin
          current_state <= STATE_IDLE;
          done_pool_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ofmap     = ofmap_q;
  assign bus.done_pool = done_pool_q;

endmodule

// File: tb/tb_maxpool.sv
module tb_maxpool;
  import cnn_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  maxpool_if #(
    .IFMAP_HEIGHT (4), .IFMAP_WIDTH (4), .OFMAP_HEIGHT (2), .OFMAP_WIDTH (2), .DATA_WIDTH (8)
  ) bus_a ();
  maxpool_if #(
    .IFMAP_HEIGHT (3), .IFMAP_WIDTH (3), .OFMAP_HEIGHT (2), .OFMAP_WIDTH (2), .DATA_WIDTH (8)
  ) bus_b ();

  maxpool #(
    .IFMAP_HEIGHT (4), .IFMAP_WIDTH (4), .POOL_HEIGHT (2), .POOL_WIDTH (2),
    .DATA_WIDTH (8), .H_STRIDE (2), .V_STRIDE (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  maxpool #(
    .IFMAP_HEIGHT (3), .IFMAP_WIDTH (3), .POOL_HEIGHT (2), .POOL_WIDTH (2),
    .DATA_WIDTH (8), .H_STRIDE (1), .V_STRIDE (1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int map_a[4][4];
  int map_b[4][4];
  int want[2][2];

  // Model state for dut_a: consumed element count of the current pass and expected outputs.
  int exp_a[2][2];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_k    = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Max of the 2x2 window whose origin is (r*vs, c*hs).
  function automatic int pool_ref(input int m[4][4], input int vs, input int hs,
                                  input int r, input int c);
    int best = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (m[r * vs + i][c * hs + j] > best) best = m[r * vs + i][c * hs + j];
    return best;
  endfunction

  task automatic apply_a();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bus_a.ifmap[r][c] = 8'(map_a[r][c]);
  endtask

  task automatic fill_a(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) map_a[r][c] = v;
    apply_a();
  endtask

  task automatic chk_map_a(input string tag);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        chk($sformatf("%s ofmap_a[%0d][%0d]", tag, r, c), int'(bus_a.ofmap[r][c]), want[r][c]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: a pass of 4 windows x 4 elements; every 4th consumed element
  // completes a window whose pooled value is the plain max over that window.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) exp_a[r][c] = 0;
      end else if (m_busy) begin
        if (!bus_a.en) begin
          m_busy = 1'b0;
        end else begin
          m_k++;
          if (m_k % 4 == 0) begin
            int w;
            w = m_k / 4 - 1;
            exp_a[w / 2][w % 2] = pool_ref(map_a, 2, 2, w / 2, w % 2);
          end
          if (m_k == 16) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (m_done) begin
        if (!bus_a.en) m_done = 1'b0;
      end else if (bus_a.en) begin
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of dut_a against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && chk_on) begin
        chk("cyc done_pool_a", int'(bus_a.done_pool), int'(m_done));
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            chk($sformatf("cyc ofmap_a[%0d][%0d]", r, c), int'(bus_a.ofmap[r][c]), exp_a[r][c]);
      end
    end
  end

  initial begin
    int pc;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    fill_a(0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) bus_b.ifmap[r][c] = 8'(r * 3 + c + 1);
    #1;
    // Reset state
    chk("rst state", int'(dut_a.current_state), int'(STATE_IDLE));
    chk("rst done_pool", int'(bus_a.done_pool), 0);
    want = '{'{0, 0}, '{0, 0}};
    chk_map_a("rst");
    chk("rst out_row", int'(dut_a.out_row), 0);
    chk("rst out_col", int'(dut_a.out_col), 0);
    tick();
    reset  = 1'b1;
    chk_on = 1'b1;

    // Default map: latency and result
    map_a = '{'{1, 5, 2, 0}, '{3, 4, 7, 1}, '{0, 0, 9, 8}, '{6, 2, 3, 255}};
    apply_a();
    chk("ref pin [0][0]", pool_ref(map_a, 2, 2, 0, 0), 5);
    chk("ref pin [1][1]", pool_ref(map_a, 2, 2, 1, 1), 255);
    bus_a.en = 1'b1;
    pc = 0;
    repeat (16) begin
      tick();
      if (dut_a.current_state == STATE_PROCESS) pc++;
    end
    chk("t1 process cycles", pc, 16);
    chk("t1 done before 17th edge", int'(bus_a.done_pool), 0);
    tick();
    chk("t1 done on 17th edge", int'(bus_a.done_pool), 1);
    chk("t1 state", int'(dut_a.current_state), int'(STATE_DONE));
    want = '{'{5, 7}, '{6, 255}};
    chk_map_a("t1");

    // Hold en in DONE: no restart, ofmap held
    repeat (10) tick();
    chk("hold state", int'(dut_a.current_state), int'(STATE_DONE));
    chk("hold done", int'(bus_a.done_pool), 1);
    chk_map_a("hold");
    bus_a.en = 1'b0;
    tick();
    chk("release state", int'(dut_a.current_state), int'(STATE_IDLE));
    chk("release done", int'(bus_a.done_pool), 0);
    chk_map_a("release");

    // All 3, all 0, all 255
    for (int k = 0; k < 3; k++) begin
      int v;
      v = (k == 0) ? 3 : (k == 1) ? 0 : 255;
      fill_a(v);
      bus_a.en = 1'b1;
      repeat (17) tick();
      chk($sformatf("fill%0d done", v), int'(bus_a.done_pool), 1);
      want = '{'{v, v}, '{v, v}};
      chk_map_a($sformatf("fill%0d", v));
      bus_a.en = 1'b0;
      tick();
    end

    // Asynchronous reset in the middle of a pass
    map_a = '{'{1, 5, 2, 0}, '{3, 4, 7, 1}, '{0, 0, 9, 8}, '{6, 2, 3, 255}};
    apply_a();
    bus_a.en = 1'b1;
    repeat (3) tick();
    chk("pre-reset state", int'(dut_a.current_state), int'(STATE_PROCESS));
    #1;
    reset = 1'b0;
    #1;
    chk("async rst state", int'(dut_a.current_state), int'(STATE_IDLE));
    chk("async rst done", int'(bus_a.done_pool), 0);
    want = '{'{0, 0}, '{0, 0}};
    chk_map_a("async rst");
    bus_a.en = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Abort after 5 PROCESS cycles, then restart from window (0,0)
    bus_a.en = 1'b1;
    pc = 0;
    repeat (5) begin
      tick();
      if (dut_a.current_state == STATE_PROCESS) pc++;
    end
    chk("abort process cycles", pc, 5);
    bus_a.en = 1'b0;
    tick();
    chk("abort state", int'(dut_a.current_state), int'(STATE_IDLE));
    chk("abort done", int'(bus_a.done_pool), 0);
    want = '{'{5, 0}, '{0, 0}};
    chk_map_a("abort");
    bus_a.en = 1'b1;
    repeat (17) tick();
    chk("restart done", int'(bus_a.done_pool), 1);
    want = '{'{5, 7}, '{6, 255}};
    chk_map_a("restart");
    bus_a.en = 1'b0;
    tick();

    // 3x3 input, stride 1: overlapping windows
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) map_b[r][c] = (r < 3 && c < 3) ? r * 3 + c + 1 : 0;
    bus_b.en = 1'b1;
    pc = 0;
    repeat (16) begin
      tick();
      if (dut_b.current_state == STATE_PROCESS) pc++;
    end
    chk("ovl process cycles", pc, 16);
    chk("ovl done before 17th edge", int'(bus_b.done_pool), 0);
    tick();
    chk("ovl done", int'(bus_b.done_pool), 1);
    want = '{'{5, 6}, '{8, 9}};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("ovl ofmap_b[%0d][%0d]", r, c), int'(bus_b.ofmap[r][c]), want[r][c]);
        chk($sformatf("ovl ref[%0d][%0d]", r, c), pool_ref(map_b, 1, 1, r, c), want[r][c]);
      end
    bus_b.en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
